// File: rtl/crumb_word_compare_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crumb_word_compare_seq_pkg
//  Brief    : Shared FSM state encoding and result codes for the sequential
//             crumb-based word comparator.
//  Revision : 1.0 - initial release
// ============================================================================
package crumb_word_compare_seq_pkg;

    // Controller state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Comparison outcome of one crumb (or of the whole word).
    typedef enum logic [1:0] {
        RES_GT = 2'd0,
        RES_EQ = 2'd1,
        RES_LT = 2'd2
    } res_t;

    // Map a result code onto the {gt, eq, lt} output triple.
    function automatic logic [2:0] res_onehot(input res_t res);
        logic [2:0] v;
        case (res)
            RES_GT:  v = 3'b100;
            RES_EQ:  v = 3'b010;
            RES_LT:  v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crumb_word_compare_seq_crumb_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : crumb_comparator
//  Brief    : Combinational 2-bit magnitude comparator, {a,b} vs {c,d}
//             (a and c are the most significant bits).
//  Revision : 1.0 - initial release
// ============================================================================
module crumb_comparator (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic gt,
    output logic eq,
    output logic lt
);

    logic w_hi_eq;

    // MSB decides unless equal, then LSB decides.
    always_comb begin
        w_hi_eq = ~(a ^ c);
        gt      = (a & ~c) | (w_hi_eq & b & ~d);
        lt      = (~a & c) | (w_hi_eq & ~b & d);
        eq      = w_hi_eq & ~(b ^ d);
    end

endmodule
`default_nettype wire

// File: rtl/crumb_word_compare_seq.sv
`default_nettype none
// ============================================================================
//  Module   : crumb_word_compare_seq
//  Brief    : Sequential WORDW-bit magnitude comparator. Scans operand crumbs
//             MSB first, one per clock, through a single crumb comparator and
//             stops at the first unequal crumb. start/busy/done handshake,
//             registered one-hot gt/eq/lt result.
//             Build option: SIGNED_CMP_EN - treat operands as two's
//             complement by biasing the sign bit of the top crumb.
//  Revision : 1.0 - initial release
// ============================================================================
module crumb_word_compare_seq
    import crumb_word_compare_seq_pkg::*;
#(
    parameter int WORDW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WORDW-1:0] op_a,
    input  logic [WORDW-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCRUMB  = WORDW / 2;
    localparam int c_IDX_W = (NCRUMB > 1) ? $clog2(NCRUMB) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(NCRUMB - 1);

    // Reject odd or too-narrow operand widths at elaboration.
    generate
        if ((WORDW < 2) || ((WORDW % 2) != 0)) begin : g_bad_wordw
            $error("crumb_word_compare_seq: WORDW must be even and >= 2");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IDX_W-1:0] r_idx;
    logic [WORDW-1:0]   r_a;
    logic [WORDW-1:0]   r_b;
    logic               r_gt;
    logic               r_eq;
    logic               r_lt;

    logic [1:0]         w_raw_a;
    logic [1:0]         w_raw_b;
    logic [1:0]         w_cr_a;
    logic [1:0]         w_cr_b;
    logic               w_c_gt;
    logic               w_c_eq;
    logic               w_c_lt;
    res_t               w_res;
    logic               w_accept;
    logic               w_finish;

    // Current crumb pair selected by the scan index.
    assign w_raw_a = r_a[{r_idx, 1'b0} +: 2];
    assign w_raw_b = r_b[{r_idx, 1'b0} +: 2];

`ifdef SIGNED_CMP_EN
    // Inverting the sign bit on the top crumb turns a two's complement
    // compare into an unsigned one; lower crumbs are magnitude bits.
    logic w_top;
    assign w_top  = (r_idx == c_IDX_TOP);
    assign w_cr_a = {w_raw_a[1] ^ w_top, w_raw_a[0]};
    assign w_cr_b = {w_raw_b[1] ^ w_top, w_raw_b[0]};
`else
    assign w_cr_a = w_raw_a;
    assign w_cr_b = w_raw_b;
`endif

    crumb_comparator u_crumb_cmp (
        .a  (w_cr_a[1]),
        .b  (w_cr_a[0]),
        .c  (w_cr_b[1]),
        .d  (w_cr_b[0]),
        .gt (w_c_gt),
        .eq (w_c_eq),
        .lt (w_c_lt)
    );

    assign w_res    = w_c_gt ? RES_GT : (w_c_lt ? RES_LT : RES_EQ);
    // start is honoured in IDLE and DONE only; DONE allows back-to-back use.
    assign w_accept = start && (r_state != ST_SCAN);
    // Scan ends on the first unequal crumb or after the LSB crumb.
    assign w_finish = (r_state == ST_SCAN) && (!w_c_eq || (r_idx == '0));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_SCAN;
            ST_SCAN: if (w_finish) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_SCAN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        busy = (r_state == ST_SCAN);
        done = (r_state == ST_DONE);
    end

    // Operand capture, scan index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= c_IDX_TOP;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= op_a;
                r_b   <= op_b;
                r_idx <= c_IDX_TOP;
            end else if ((r_state == ST_SCAN) && w_c_eq && (r_idx != '0)) begin
                r_idx <= r_idx - 1'b1;
            end
            if (w_finish) begin
                {r_gt, r_eq, r_lt} <= res_onehot(w_res);
            end
        end
    end

    assign gt = r_gt;
    assign eq = r_eq;
    assign lt = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_crumb_word_compare_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crumb_word_compare_seq
//  Brief    : Directed self-checking bench for crumb_word_compare_seq
//             (WORDW = 8). Inputs change and outputs are sampled on the
//             falling edge. Observed vector is {busy, done, gt, eq, lt}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crumb_word_compare_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;

    int n_checks;
    int n_errors;

    crumb_word_compare_seq #(.WORDW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_a = 8'hFF; op_b = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, gt, eq, lt} !== 5'b00000) begin
                n_errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, {busy, done, gt, eq, lt}, 5'b00000);
            end
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, gt, eq, lt} !== 5'b00000) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: got %b expected %b", i, {busy, done, gt, eq, lt}, 5'b00000);
            end
        end
    endtask

    // Start a compare and count crumb cycles until done; check result.
    task automatic run_compare(input string name, input logic [7:0] a, input logic [7:0] b,
                               input int exp_k, input logic [2:0] exp_res);
        int k;
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== exp_k) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, k, exp_k);
        end
        n_checks++;
        if ({busy, done, gt, eq, lt} !== {2'b01, exp_res}) begin
            n_errors++;
            $display("FAIL %s_result: got %b expected %b", name, {busy, done, gt, eq, lt}, {2'b01, exp_res});
        end
    endtask

    task automatic test_best_case();
        op_a = 8'hB4; op_b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++;
            $display("FAIL best_scan: got busy,done=%b expected %b", {busy, done}, 2'b10);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b01100) begin
            n_errors++;
            $display("FAIL best_done: got %b expected %b", {busy, done, gt, eq, lt}, 5'b01100);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b00100) begin
            n_errors++;
            $display("FAIL best_hold: got %b expected %b", {busy, done, gt, eq, lt}, 5'b00100);
        end
    endtask

    task automatic test_full_scan();
        run_compare("equal", 8'h5A, 8'h5A, 4, 3'b010);
        @(negedge clk);
        run_compare("lsb_lt", 8'h5A, 8'h5B, 4, 3'b001);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        op_a = 8'h10; op_b = 8'h20; start = 1'b1;
        @(negedge clk);
        // Mid-scan operand change and second start must be ignored.
        op_a = 8'hFF; start = 1'b1;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++;
            $display("FAIL b2b_scan1: got busy,done=%b expected %b", {busy, done}, 2'b10);
        end
        @(negedge clk);
        op_a = 8'hC0; op_b = 8'h40; start = 1'b1;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++;
            $display("FAIL b2b_scan2: got busy,done=%b expected %b", {busy, done}, 2'b10);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b01001) begin
            n_errors++;
            $display("FAIL b2b_first: got %b expected %b", {busy, done, gt, eq, lt}, 5'b01001);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b10001) begin
            n_errors++;
            $display("FAIL b2b_no_idle: got %b expected %b", {busy, done, gt, eq, lt}, 5'b10001);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b01100) begin
            n_errors++;
            $display("FAIL b2b_second: got %b expected %b", {busy, done, gt, eq, lt}, 5'b01100);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        op_a = 8'h5A; op_b = 8'h5B; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b00000) begin
            n_errors++;
            $display("FAIL midrst_clear: got %b expected %b", {busy, done, gt, eq, lt}, 5'b00000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, gt, eq, lt} !== 5'b00000) begin
                n_errors++;
                $display("FAIL midrst_quiet[%0d]: got %b expected %b", i, {busy, done, gt, eq, lt}, 5'b00000);
            end
        end
    endtask

    task automatic test_sign_bias();
`ifdef SIGNED_CMP_EN
        run_compare("sign", 8'h80, 8'h01, 1, 3'b001);
`else
        run_compare("sign", 8'h80, 8'h01, 1, 3'b100);
`endif
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        test_reset();
        test_best_case();
        test_full_scan();
        test_back_to_back();
        test_mid_reset();
        test_sign_bias();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
